// File: rtl/coin_credit_fsm.sv
// Coin-credit controller: accumulates coin credit, starts brewing on a paid selection, returns change.
// Optional inactivity refund in ACCUM is enabled by defining COIN_TIMEOUT_REFUND_EN.
module coin_credit_fsm #(
  parameter int unsigned NUM_COINS      = 2,
  parameter int unsigned COIN_VAL0      = 100,
  parameter int unsigned COIN_VAL1      = 500,
  parameter int unsigned COIN_VAL2      = 0,
  parameter int unsigned COIN_VAL3      = 0,
  parameter int unsigned CREDIT_W       = 12,
  parameter int unsigned MAX_CREDIT     = 3000,
  parameter int unsigned TIMEOUT_CYCLES = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_id,
  input  logic                sel_valid,
  input  logic [CREDIT_W-1:0] price,
  input  logic                cancel,
  input  logic                brew_done,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                brew_en,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                busy
);

  localparam int unsigned SumW = CREDIT_W + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StDispense, StChange} state_e;

  state_e state_q;

  function automatic logic [SumW-1:0] coin_value(input logic [1:0] id);
    logic [SumW-1:0] v;
    case (id)
      2'd0:    v = SumW'(COIN_VAL0);
      2'd1:    v = SumW'(COIN_VAL1);
      2'd2:    v = SumW'(COIN_VAL2);
      default: v = SumW'(COIN_VAL3);
    endcase
    return v;
  endfunction

  // One extra bit on the sum so the ceiling test cannot be fooled by wrap-around.
  logic [SumW-1:0] coin_sum;
  logic            id_ok;
  logic            coin_ok;
  logic            can_pay;
  logic            tmo_hit;

  assign coin_sum = {1'b0, credit} + coin_value(coin_id);
  assign id_ok    = 32'(coin_id) < NUM_COINS;
  assign coin_ok  = id_ok && (coin_sum <= SumW'(MAX_CREDIT));
  assign can_pay  = credit >= price;

`ifdef COIN_TIMEOUT_REFUND_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q;
  logic            tmo_restart;

  assign tmo_restart = !cancel && ((sel_valid && !can_pay) || (!sel_valid && coin_valid && coin_ok));
  assign tmo_hit     = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q != StAccum || tmo_restart) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      credit       <= '0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      brew_en      <= 1'b0;
      change_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      unique case (state_q)
        StIdle, StAccum: begin
          if (cancel) begin
            coin_reject <= coin_valid;
            if (state_q == StAccum) begin
              change_amt   <= credit;
              credit       <= '0;
              change_valid <= 1'b1;
              busy         <= 1'b1;
              state_q      <= StChange;
            end
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            if (can_pay) begin
              change_amt <= credit - price;
              credit     <= '0;
              brew_en    <= 1'b1;
              busy       <= 1'b1;
              state_q    <= StDispense;
            end else begin
              insufficient <= 1'b1;
            end
          end else if (coin_valid) begin
            if (coin_ok) begin
              credit  <= coin_sum[CREDIT_W-1:0];
              state_q <= StAccum;
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (state_q == StAccum && tmo_hit) begin
            change_amt   <= credit;
            credit       <= '0;
            change_valid <= 1'b1;
            busy         <= 1'b1;
            state_q      <= StChange;
          end
        end
        StDispense: begin
          coin_reject <= coin_valid;
          if (brew_done) begin
            brew_en <= 1'b0;
            if (change_amt != '0) begin
              change_valid <= 1'b1;
              state_q      <= StChange;
            end else begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        StChange: begin
          coin_reject <= coin_valid;
          if (change_ack) begin
            change_valid <= 1'b0;
            change_amt   <= '0;
            busy         <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Scoreboard bench for coin_credit_fsm: stimulus queues expected output events, a monitor checks them.
module tb_coin_credit_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coin_valid = 1'b0;
  logic [1:0]  coin_id = 2'd0;
  logic        sel_valid = 1'b0;
  logic [11:0] price = 12'd0;
  logic        cancel = 1'b0;
  logic        brew_done = 1'b0;
  logic        change_ack = 1'b0;
  logic [11:0] credit;
  logic        coin_reject;
  logic        insufficient;
  logic        brew_en;
  logic        change_valid;
  logic [11:0] change_amt;
  logic        busy;

  coin_credit_fsm #(
    .NUM_COINS(2), .COIN_VAL0(100), .COIN_VAL1(500), .COIN_VAL2(0), .COIN_VAL3(0),
    .CREDIT_W(12), .MAX_CREDIT(3000), .TIMEOUT_CYCLES(30)
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_id(coin_id),
    .sel_valid(sel_valid), .price(price), .cancel(cancel), .brew_done(brew_done),
    .change_ack(change_ack), .credit(credit), .coin_reject(coin_reject),
    .insufficient(insufficient), .brew_en(brew_en), .change_valid(change_valid),
    .change_amt(change_amt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef enum int {EvCredit, EvReject, EvInsuf, EvBrew, EvChange, EvIdle} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [11:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  task automatic expect_ev(input ev_kind_e k, input logic [11:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_e k, input logic [11:0] v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected event %s value=%0d (nothing expected)", k.name(), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        bad++;
        $display("FAIL event: got %s=%0d expected %s=%0d", k.name(), v, e.kind.name(), e.val);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: turns output changes into events and matches them against the queue.
  logic [11:0] p_credit = 12'd0;
  logic        p_brew = 1'b0, p_cv = 1'b0, p_busy = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (credit != p_credit)     check_ev(EvCredit, credit);
        if (coin_reject)            check_ev(EvReject, credit);
        if (insufficient)           check_ev(EvInsuf, credit);
        if (brew_en && !p_brew)     check_ev(EvBrew, credit);
        if (change_valid && !p_cv)  check_ev(EvChange, change_amt);
        if (!busy && p_busy)        check_ev(EvIdle, change_amt);
      end
      p_credit = credit;
      p_brew   = brew_en;
      p_cv     = change_valid;
      p_busy   = busy;
    end
  end

  task automatic drive(input logic cv, input logic [1:0] id, input logic sv, input logic [11:0] p,
                       input logic cn, input logic bd, input logic ca);
    @(posedge clk); #1;
    coin_valid = cv; coin_id = id; sel_valid = sv; price = p;
    cancel = cn; brew_done = bd; change_ack = ca;
    @(posedge clk); #1;
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; brew_done = 1'b0; change_ack = 1'b0;
  endtask

  task automatic coin(input logic [1:0] id);   drive(1'b1, id, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0); endtask
  task automatic sel(input logic [11:0] p);    drive(1'b0, 2'd0, 1'b1, p, 1'b0, 1'b0, 1'b0);   endtask
  task automatic do_cancel();                  drive(1'b0, 2'd0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic brew();                       drive(1'b0, 2'd0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0); endtask
  task automatic ack();                        drive(1'b0, 2'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b1); endtask

  // Bounded wait for all expected events; leftovers count as failures.
  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing event %s value=%0d", e.kind.name(), e.val);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " credit"}, int'(credit), 0);
    chk({tag, " change_amt"}, int'(change_amt), 0);
    chk({tag, " coin_reject"}, int'(coin_reject), 0);
    chk({tag, " insufficient"}, int'(insufficient), 0);
    chk({tag, " brew_en"}, int'(brew_en), 0);
    chk({tag, " change_valid"}, int'(change_valid), 0);
    chk({tag, " busy"}, int'(busy), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all_zero("reset");

    // Basic purchase with change
    expect_ev(EvCredit, 100);  coin(2'd0);
    expect_ev(EvCredit, 600);  coin(2'd1);
    expect_ev(EvCredit, 0);    expect_ev(EvBrew, 0);  sel(12'd500);
    expect_ev(EvChange, 100);  brew();
    expect_ev(EvIdle, 0);      ack();
    drain();
    chk("credit after purchase", int'(credit), 0);

    // Insufficient, then top up
    expect_ev(EvCredit, 500);  coin(2'd1);
    expect_ev(EvCredit, 600);  coin(2'd0);
    expect_ev(EvInsuf, 600);   sel(12'd800);
    expect_ev(EvCredit, 1100); coin(2'd1);
    expect_ev(EvCredit, 0);    expect_ev(EvBrew, 0);  sel(12'd800);
    expect_ev(EvChange, 300);  brew();
    expect_ev(EvIdle, 0);      ack();
    drain();

    // Exact payment goes straight back to idle
    expect_ev(EvCredit, 500);  coin(2'd1);
    expect_ev(EvCredit, 0);    expect_ev(EvBrew, 0);  sel(12'd500);
    expect_ev(EvIdle, 0);      brew();
    drain();
    chk("exact change_valid", int'(change_valid), 0);

    // Saturation and invalid denomination
    for (int i = 1; i <= 6; i++) begin
      expect_ev(EvCredit, 12'(500 * i));
      coin(2'd1);
    end
    expect_ev(EvReject, 3000); coin(2'd0);
    expect_ev(EvReject, 3000); coin(2'd2);
    drain();
    chk("saturated credit", int'(credit), 3000);
    expect_ev(EvCredit, 0);    expect_ev(EvChange, 3000); do_cancel();
    expect_ev(EvIdle, 0);      ack();
    drain();

    // Coin together with cancel
    expect_ev(EvCredit, 500);  coin(2'd1);
    expect_ev(EvCredit, 0);    expect_ev(EvReject, 0);  expect_ev(EvChange, 500);
    drive(1'b1, 2'd0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    expect_ev(EvIdle, 0);      ack();
    drain();

    // Coin with selection, then events during DISPENSE/CHANGE, then reset in CHANGE
    expect_ev(EvCredit, 500);  coin(2'd1);
    expect_ev(EvCredit, 0);    expect_ev(EvReject, 0);  expect_ev(EvBrew, 0);
    drive(1'b1, 2'd0, 1'b1, 12'd200, 1'b0, 1'b0, 1'b0);
    expect_ev(EvReject, 0);    coin(2'd0);
    sel(12'd0);
    do_cancel();
    drain();
    chk("busy in dispense", int'(busy), 1);
    chk("brew_en in dispense", int'(brew_en), 1);
    expect_ev(EvChange, 300);  brew();
    expect_ev(EvReject, 0);    coin(2'd1);
    drain();
    chk("change_amt held", int'(change_amt), 300);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk_all_zero("reset in change");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Idle-state corner cases
    do_cancel();
    brew();
    ack();
    expect_ev(EvInsuf, 0);     sel(12'd100);
    expect_ev(EvBrew, 0);      sel(12'd0);
    expect_ev(EvIdle, 0);      brew();
    drain();

    // Credit hold / inactivity refund
    expect_ev(EvCredit, 100);  coin(2'd0);
    drain();
`ifdef COIN_TIMEOUT_REFUND_EN
    expect_ev(EvCredit, 0);    expect_ev(EvChange, 100);
    repeat (40) @(posedge clk);
    drain();
    chk("timeout change_valid", int'(change_valid), 1);
    expect_ev(EvIdle, 0);      ack();
    drain();
`else
    repeat (100) @(posedge clk);
    chk("held credit", int'(credit), 100);
    chk("held busy", int'(busy), 0);
    expect_ev(EvCredit, 0);    expect_ev(EvChange, 100); do_cancel();
    expect_ev(EvIdle, 0);      ack();
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
